// File: rtl/relay_scan_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : relay_scan_sequencer_if
// Description : Bundle of the scan control and relay-drive signals shared
//               between the relay scan sequencer and whatever drives it.
//               start        - begin a scan (from controller)
//               relay_out    - combined relay network output (from network)
//               switches     - per-relay switch drive
//               batt         - battery enable to all relays
//               busy         - scan in progress
//               sample_valid - one-cycle pulse when relay_out is captured
//               sample_index - combination being captured
//               truth_table  - assembled network truth table
//               done         - one-cycle end-of-scan pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface relay_scan_sequencer_if #(
    parameter int N_SWITCHES = 2
);
    logic                       start;
    logic                       relay_out;
    logic [N_SWITCHES-1:0]      switches;
    logic                       batt;
    logic                       busy;
    logic                       sample_valid;
    logic [N_SWITCHES-1:0]      sample_index;
    logic [(2**N_SWITCHES)-1:0] truth_table;
    logic                       done;

    // Controller / environment side
    modport master (
        output start,
        output relay_out,
        input  switches,
        input  batt,
        input  busy,
        input  sample_valid,
        input  sample_index,
        input  truth_table,
        input  done
    );

    // Sequencer side
    modport slave (
        input  start,
        input  relay_out,
        output switches,
        output batt,
        output busy,
        output sample_valid,
        output sample_index,
        output truth_table,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/relay_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : relay_scan_sequencer
// Description : Drives every switch combination of a small relay network in
//               binary order with the battery applied, waits SETTLE_CYCLES for
//               the relays to pull in, samples the combined output and builds
//               a truth table. One start pulse characterises the whole gate.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-high reset
//               bus   - relay_scan_sequencer_if.slave (start, relay_out in;
//                       switches, batt, busy, sample_valid, sample_index,
//                       truth_table, done out)
// Revision    : 1.0 - initial release
// ============================================================================
module relay_scan_sequencer #(
    parameter int N_SWITCHES    = 2,   // 1..4
    parameter int SETTLE_CYCLES = 3    // 1..15
) (
    input  wire logic             clk,
    input  wire logic             reset,
    relay_scan_sequencer_if.slave bus
);

    localparam int                    c_COMBOS   = 2**N_SWITCHES;
    localparam logic [N_SWITCHES-1:0] c_IDX_MAX  = N_SWITCHES'(c_COMBOS - 1);
    localparam logic [N_SWITCHES-1:0] c_IDX_ONE  = N_SWITCHES'(1);
    localparam logic [3:0]            c_CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N_SWITCHES-1:0] r_index;
    logic [N_SWITCHES-1:0] w_index_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic [c_COMBOS-1:0]   r_tt;
    logic [c_COMBOS-1:0]   w_tt_nxt;
    logic                  w_active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_cnt   <= '0;
            r_tt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tt    <= w_tt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_cnt_nxt   = r_cnt;
        w_tt_nxt    = r_tt;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_SETTLE;
                    w_index_nxt = '0;
                    w_cnt_nxt   = c_CNT_LOAD;
                    w_tt_nxt    = '0;
                end
            end
            ST_SETTLE: begin
                // Counter was preloaded with SETTLE_CYCLES-1, so reaching zero
                // here means this is the last settle cycle.
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_SAMPLE: begin
                w_tt_nxt[r_index] = bus.relay_out;
                // Exit is taken at the maximum index, so the increment below
                // never wraps.
                if (r_index == c_IDX_MAX) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SETTLE;
                    w_index_nxt = r_index + c_IDX_ONE;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // All outputs decode from registered state only, so reset clears them
    // asynchronously and relay_out/start never reach an output directly.
    assign w_active         = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign bus.batt         = w_active;
    assign bus.busy         = w_active;
    assign bus.switches     = w_active ? r_index : '0;
    assign bus.sample_valid = (r_state == ST_SAMPLE);
    assign bus.sample_index = (r_state == ST_SAMPLE) ? r_index : '0;
    assign bus.done         = (r_state == ST_DONE);
    assign bus.truth_table  = r_tt;

endmodule
`default_nettype wire

// File: tb/tb_relay_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_relay_scan_sequencer
// Description : Self-checking bench for relay_scan_sequencer. Instance A uses
//               the default parameters (2 switches, 3 settle cycles) and is
//               exercised from a vector table; instance B (1 switch, 1 settle
//               cycle) runs a hand-written inverter scan. Expected sample and
//               done events are queued when a scan starts and popped when the
//               DUT reports them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relay_scan_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    relay_scan_sequencer_if #(.N_SWITCHES(2)) bus_a ();
    relay_scan_sequencer_if #(.N_SWITCHES(1)) bus_b ();

    relay_scan_sequencer #(.N_SWITCHES(2), .SETTLE_CYCLES(3)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    relay_scan_sequencer #(.N_SWITCHES(1), .SETTLE_CYCLES(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic tog = 1'b0;
    always @(posedge clk) tog <= ~tog;

    typedef struct {
        int          cyc;
        bit          is_done;
        logic [3:0]  idx;
        logic [15:0] tt;
    } ev_t;

    typedef struct {
        int         mode;     // 0 series, 1 parallel, 2 xor
        bit         glitch;   // toggle relay_out every SETTLE cycle
        bit         restart;  // re-pulse start in SETTLE and SAMPLE
        logic [3:0] exp_tt;
    } vec_t;

    ev_t  qa[$];
    ev_t  qb[$];
    vec_t vecs[5];

    int mode_a   = 0;
    bit glitch_a = 1'b0;

    function automatic logic net(input int mode, input logic [1:0] sw);
        case (mode)
            0:       return sw[0] & sw[1];
            1:       return sw[0] | sw[1];
            2:       return sw[0] ^ sw[1];
            default: return 1'b0;
        endcase
    endfunction

    always_comb bus_a.relay_out = net(mode_a, bus_a.switches)
                                  ^ (glitch_a & bus_a.busy & ~bus_a.sample_valid & tog);
    always_comb bus_b.relay_out = ~bus_b.switches[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor, instance A
    always @(negedge clk) begin
        ev_t e;
        int  mask;
        if (bus_a.sample_valid || bus_a.done) begin
            if (qa.size() == 0) begin
                check("a_unexpected_event", {30'b0, bus_a.sample_valid, bus_a.done}, 32'd0);
            end else begin
                e = qa.pop_front();
                check("a_event_cycle", cyc, e.cyc);
                check("a_event_kind", {31'b0, bus_a.done}, {31'b0, e.is_done});
                if (e.is_done) begin
                    check("a_tt_at_done", {28'b0, bus_a.truth_table}, {16'b0, e.tt});
                end else begin
                    mask = (1 << e.idx) - 1;
                    check("a_sample_index", {30'b0, bus_a.sample_index}, {28'b0, e.idx});
                    check("a_tt_partial", {28'b0, bus_a.truth_table} & mask, {16'b0, e.tt} & mask);
                end
            end
        end
    end

    // Scoreboard monitor, instance B
    always @(negedge clk) begin
        ev_t e;
        int  mask;
        if (bus_b.sample_valid || bus_b.done) begin
            if (qb.size() == 0) begin
                check("b_unexpected_event", {30'b0, bus_b.sample_valid, bus_b.done}, 32'd0);
            end else begin
                e = qb.pop_front();
                check("b_event_cycle", cyc, e.cyc);
                check("b_event_kind", {31'b0, bus_b.done}, {31'b0, e.is_done});
                if (e.is_done) begin
                    check("b_tt_at_done", {30'b0, bus_b.truth_table}, {16'b0, e.tt});
                end else begin
                    mask = (1 << e.idx) - 1;
                    check("b_sample_index", {31'b0, bus_b.sample_index}, {28'b0, e.idx});
                    check("b_tt_partial", {30'b0, bus_b.truth_table} & mask, {16'b0, e.tt} & mask);
                end
            end
        end
    end

    // Queue the expected events of a full instance-A scan started in cycle t0.
    task automatic push_scan_a(input int t0, input logic [3:0] exp_tt);
        for (int k = 0; k < 4; k++)
            qa.push_back('{t0 + (k + 1) * 4, 1'b0, 4'(k), {12'b0, exp_tt}});
        qa.push_back('{t0 + 17, 1'b1, 4'd0, {12'b0, exp_tt}});
    endtask

    task automatic run_scan(input vec_t v);
        int t0;
        bit exp_busy;
        @(negedge clk);
        mode_a   = v.mode;
        glitch_a = v.glitch;
        t0       = cyc;
        push_scan_a(t0, v.exp_tt);
        bus_a.start = 1'b1;
        for (int r = 1; r <= 18; r++) begin
            @(negedge clk);
            bus_a.start = v.restart && (r == 2 || r == 8);
            exp_busy = (r <= 16);
            check("a_busy", {31'b0, bus_a.busy}, {31'b0, exp_busy});
            check("a_batt", {31'b0, bus_a.batt}, {31'b0, exp_busy});
            check("a_switches", {30'b0, bus_a.switches}, exp_busy ? 32'((r - 1) / 4) : 32'd0);
        end
        check("a_queue_drained", qa.size(), 32'd0);
        check("a_tt_hold", {28'b0, bus_a.truth_table}, {28'b0, v.exp_tt});
        glitch_a = 1'b0;
    endtask

    initial begin
        int t0;
        vecs[0] = '{0, 1'b0, 1'b0, 4'b1000};
        vecs[1] = '{1, 1'b0, 1'b0, 4'b1110};
        vecs[2] = '{0, 1'b0, 1'b1, 4'b1000};
        vecs[3] = '{2, 1'b1, 1'b0, 4'b0110};
        vecs[4] = '{1, 1'b1, 1'b1, 4'b1110};

        reset       = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_switches",     {30'b0, bus_a.switches},     32'd0);
        check("rst_batt",         {31'b0, bus_a.batt},         32'd0);
        check("rst_busy",         {31'b0, bus_a.busy},         32'd0);
        check("rst_sample_valid", {31'b0, bus_a.sample_valid}, 32'd0);
        check("rst_sample_index", {30'b0, bus_a.sample_index}, 32'd0);
        check("rst_truth_table",  {28'b0, bus_a.truth_table},  32'd0);
        check("rst_done",         {31'b0, bus_a.done},         32'd0);
        check("rst_b_truth_table", {30'b0, bus_b.truth_table}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_scan(vecs[i]);

        // Reset during SETTLE of combination 2 on a parallel network
        @(negedge clk);
        mode_a = 1;
        t0     = cyc;
        push_scan_a(t0, 4'b1110);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_busy", {31'b0, bus_a.busy}, 32'd1);
        check("mid_partial_tt", {28'b0, bus_a.truth_table}, 32'b0010);
        #1 reset = 1'b1;
        qa.delete();
        #1;
        check("rst_mid_batt",     {31'b0, bus_a.batt},        32'd0);
        check("rst_mid_switches", {30'b0, bus_a.switches},    32'd0);
        check("rst_mid_tt",       {28'b0, bus_a.truth_table}, 32'd0);
        check("rst_mid_busy",     {31'b0, bus_a.busy},        32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 20; r++) begin
            @(negedge clk);
            check("post_rst_idle", {30'b0, bus_a.busy, bus_a.done}, 32'd0);
        end
        run_scan(vecs[1]);

        // Instance B: one switch, one settle cycle, inverter network
        @(negedge clk);
        t0 = cyc;
        qb.push_back('{t0 + 2, 1'b0, 4'd0, 16'b01});
        qb.push_back('{t0 + 4, 1'b0, 4'd1, 16'b01});
        qb.push_back('{t0 + 5, 1'b1, 4'd0, 16'b01});
        bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        check("b_busy_settle", {31'b0, bus_b.busy}, 32'd1);
        repeat (8) @(negedge clk);
        check("b_queue_drained", qb.size(), 32'd0);
        check("b_tt_hold", {30'b0, bus_b.truth_table}, 32'b01);
        check("b_idle", {30'b0, bus_b.busy, bus_b.batt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
